bilateral_norm_div: RTL
=======================

BILATERAL_NORM_DIV -- requirements
Module: bilateral_norm_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous active-high reset.
REQ-003 in_valid  input  1  num/den valid this cycle.
REQ-004 in_ready  output  1  block can accept an operand pair.
REQ-005 num  input  35  unsigned weighted-pixel sum (window accumulator output).
REQ-006 den  input  27  unsigned weight sum for the same window.
REQ-007 out_valid  output  1  pix/div_zero valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 pix  output  8  normalized filtered pixel, num/den.
REQ-010 div_zero  output  1  den was zero for this result.

Function
REQ-011 States SHALL be IDLE, CHECK, DIV and DONE; in_ready SHALL be 1 only in IDLE.
REQ-012 Accept: in_valid&in_ready at edge of cycle t SHALL register num into remainder R and den into D, and enter CHECK for cycle t+1; in_valid is ignored outside IDLE.
REQ-013 CHECK, den==0: pix=0, div_zero=1, go to DONE (out_valid in t+2).
REQ-014 CHECK, num >= D*256 (35-bit compare against D<<8): pix=255, div_zero=0, go to DONE (out_valid in t+2).
REQ-015 CHECK, otherwise: clear quotient, set bit index i=7, go to DIV.
REQ-016 DIV: one restoring step per cycle, i=7 down to 0: if R >= (D<<i), R -= D<<i and q[i]=1, else q[i]=0; all compares/subtracts unsigned at 35 bits, no truncation.
REQ-017 DIV SHALL last exactly 8 cycles (t+2..t+9) without rounding; out_valid first asserts in t+10.
REQ-018 With rounding (REQ-027), one extra DIV cycle SHALL follow step i=0; out_valid first asserts in t+11.
REQ-019 DONE: out_valid=1; pix and div_zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 out_valid&out_ready at an edge SHALL return to IDLE; in_ready=1 in the next cycle (no same-cycle accept in DONE).
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 pix/div_zero SHALL hold last result in IDLE/CHECK/DIV; only out_valid qualifies them.
REQ-023 Result SHALL equal floor(num/den) clamped to 255 (truncation build) for all 35-bit num, 27-bit den != 0.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, pix=0, div_zero=0, R=0, D=0, q=0, i=0.
REQ-025 Reset asserted mid-DIV or in DONE SHALL discard the operation; no out_valid after rst deasserts until a new accept.
REQ-026 in_valid in the cycle reset deasserts SHALL be accepted normally (in_ready=1).

Configuration
REQ-027 Macro BILATERAL_NORM_ROUND_EN defined: extra DIV cycle computes round-half-up: if 2*R >= D then q+1, saturated at 255; latency per REQ-018.
REQ-028 Macro undefined: pix = truncated quotient, latency per REQ-017; CHECK-path results (REQ-013/014) and their latency are identical in both builds.

Verification
REQ-029 Reset, then num=25500, den=100, out_ready=1 -> in_ready drops, out_valid in t+10 (t+11 ROUND), pix=255? no: 25500 >= 25600 false -> pix=255 via DIV, div_zero=0.
REQ-030 num=1000, den=300 -> pix=3 (truncation), pix=3 (ROUND, 1000/300=3.33); num=1050, den=300 -> pix=3 truncation, pix=4 ROUND.
REQ-031 num=34359738367 (2^35-1), den=1 -> saturation path, pix=255, out_valid in t+2 both builds; num=5, den=0 -> pix=0, div_zero=1 in t+2.
REQ-032 Backpressure: out_ready=0 for 20 cycles after out_valid -> pix stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle, then new pair accepted.
REQ-033 Assert rst in cycle t+5 of num=1000, den=300 -> out_valid=0, in_ready=1 immediately; no stale result after release.
REQ-034 Random 10^5 pairs (den 1..2^27-1, num 0..2^35-1) vs golden floor/round model with random out_ready -> zero mismatches.

Source files
------------

// File: rtl/bilateral_norm_div.sv
// Bilateral filter normalizer: pix = num/den via 8-step restoring division, clamped to 255.
// Define BILATERAL_NORM_ROUND_EN to add a round-half-up cycle after the last quotient bit.
module bilateral_norm_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [34:0] num,
  input  logic [26:0] den,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  pix,
  output logic        div_zero
);

  localparam int unsigned NW = 35;
  localparam int unsigned DW = 27;
  localparam int unsigned QW = 8;
  localparam int unsigned IW = 3;
`ifdef BILATERAL_NORM_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  state_t          state, state_n;
  logic [NW-1:0]   r, r_n;
  logic [DW-1:0]   d, d_n;
  logic [QW-1:0]   q, q_n, pix_n;
  logic [IW-1:0]   i, i_n;
  logic            rnd, rnd_n;
  logic            div_zero_n;
  logic [NW-1:0]   d_sh;
  logic [NW:0]     r_x2;

  assign d_sh = NW'(d) << i;
  assign r_x2 = {r, 1'b0};

  // Next-state and datapath
  always_comb begin
    state_n    = state;
    r_n        = r;
    d_n        = d;
    q_n        = q;
    i_n        = i;
    rnd_n      = rnd;
    pix_n      = pix;
    div_zero_n = div_zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          r_n     = num;
          d_n     = den;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (d == '0) begin
          pix_n      = '0;
          div_zero_n = 1'b1;
          state_n    = DONE;
        end else if (r >= (NW'(d) << 8)) begin
          pix_n      = '1;
          div_zero_n = 1'b0;
          state_n    = DONE;
        end else begin
          q_n     = '0;
          i_n     = IW'(7);
          state_n = DIV;
        end
      end
      DIV: begin
        if (rnd) begin
          // Remainder is below d here, so 2*r fits the widened compare
          rnd_n      = 1'b0;
          pix_n      = ((r_x2 >= (NW + 1)'(d)) && (q != '1)) ? q + QW'(1) : q;
          div_zero_n = 1'b0;
          state_n    = DONE;
        end else begin
          if (r >= d_sh) begin
            r_n    = r - d_sh;
            q_n[i] = 1'b1;
          end else begin
            q_n[i] = 1'b0;
          end
          if (i == '0) begin
            if (ROUND_EN) begin
              rnd_n = 1'b1;
            end else begin
              pix_n      = q_n;
              div_zero_n = 1'b0;
              state_n    = DONE;
            end
          end else begin
            i_n = i - IW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      d         <= '0;
      q         <= '0;
      i         <= '0;
      rnd       <= 1'b0;
      pix       <= '0;
      div_zero  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      d         <= d_n;
      q         <= q_n;
      i         <= i_n;
      rnd       <= rnd_n;
      pix       <= pix_n;
      div_zero  <= div_zero_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

endmodule
